// File: rtl/tlk2711_pkg.sv
// Shared definitions for the TLK2711 link self-test controller.
// Holds the controller state encodings, result codes, the 8b/10b control
// and data characters used on the link, and the frame header words.
package tlk2711_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RESET = 3'd1,
    ST_LOCK  = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    RES_PASS     = 2'd0,
    RES_DATA_ERR = 2'd1,
    RES_TIMEOUT  = 2'd2,
    RES_ABORT    = 2'd3
  } result_e;

  // 8b/10b characters (unencoded byte values)
  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] D5_6  = 8'hC5;
  localparam logic [7:0] K27_7 = 8'hFB;
  localparam logic [7:0] K28_2 = 8'h5C;
  localparam logic [7:0] K30_7 = 8'hFE;
  localparam logic [7:0] K29_7 = 8'hFD;

  // Idle/sync word and frame header words sent by the test generator
  localparam logic [15:0] SYNC_WORD = {D5_6, K28_5};
  localparam logic [15:0] HEAD_0    = 16'hEB90;
  localparam logic [15:0] HEAD_1    = 16'h146F;

  // Longest allowed run of cycles between sync pulses while locking
  localparam logic [6:0] SYNC_GAP_MAX = 7'd64;

endpackage

// File: rtl/tlk2711_sat_cnt.sv
// Saturating up-counter with synchronous clear.
// Ports: clk, rst (sync, active-high), clr_i (clear, wins over enable),
//        en_i (count enable), cnt_o (registered count, holds at all-ones).
module tlk2711_sat_cnt #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/tlk2711_link_test_ctrl.sv
// TLK2711 link self-test sequencer for one channel.
// Resets the rx checker, enables tx test frames, waits for sync lock, then
// checks a programmed number of frames, counting checker errors.
// Ports: clk/rst (sync, active-high); i_start/i_stop control pulses;
//   i_frame_num (0 = continuous), i_timeout (0 = disabled) latched at start;
//   i_sync_det/i_frame_done/i_check_error/i_error_status from the checker;
//   o_soft_rst/o_tx_test_en/o_rx_start_test to generator/checker;
//   o_busy/o_done/o_result/o_frame_cnt/o_err_cnt/o_first_err/o_state status.
module tlk2711_link_test_ctrl
  import tlk2711_pkg::*;
#(
  parameter int unsigned RST_CYCLES = 16,
  parameter int unsigned LOCK_SYNCS = 8,
  parameter int unsigned TMO_WIDTH  = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic                 i_stop,
  input  logic [15:0]          i_frame_num,
  input  logic [TMO_WIDTH-1:0] i_timeout,
  input  logic                 i_sync_det,
  input  logic                 i_frame_done,
  input  logic                 i_check_error,
  input  logic [3:0]           i_error_status,
  output logic                 o_soft_rst,
  output logic                 o_tx_test_en,
  output logic                 o_rx_start_test,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [1:0]           o_result,
  output logic [15:0]          o_frame_cnt,
  output logic [15:0]          o_err_cnt,
  output logic [3:0]           o_first_err,
  output logic [2:0]           o_state
);

  localparam int unsigned RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int unsigned SCW = $clog2(LOCK_SYNCS + 1);
  localparam logic [RCW-1:0] RST_LAST  = RCW'(RST_CYCLES - 1);
  localparam logic [SCW-1:0] SYNC_LOCK = SCW'(LOCK_SYNCS);

  state_e               state_q, state_d;
  result_e              result_q, result_d;
  logic [15:0]          frame_num_q, frame_num_d;
  logic [TMO_WIDTH-1:0] tmo_lim_q, tmo_lim_d;
  logic [TMO_WIDTH-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [15:0]          frame_cnt_q, frame_cnt_d;
  logic [3:0]           first_err_q, first_err_d;
  logic [RCW-1:0]       rst_cnt_q, rst_cnt_d;
  logic [SCW-1:0]       sync_cnt_q, sync_cnt_d;
  logic [6:0]           gap_cnt_q, gap_cnt_d;
  logic                 err_prev_q, err_prev_d;
  logic                 soft_rst_q, tx_en_q, rx_en_q, busy_q, done_q;
  logic                 err_edge, err_clr, tmo_hit;

  assign err_edge = (state_q == ST_RUN) && i_check_error && !err_prev_q;
  assign tmo_hit  = (tmo_lim_q != '0) && (tmo_cnt_q == tmo_lim_q);

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    frame_num_d = frame_num_q;
    tmo_lim_d   = tmo_lim_q;
    tmo_cnt_d   = tmo_cnt_q;
    frame_cnt_d = frame_cnt_q;
    first_err_d = first_err_q;
    rst_cnt_d   = rst_cnt_q;
    sync_cnt_d  = sync_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    err_prev_d  = err_prev_q;
    err_clr     = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          state_d     = ST_RESET;
          frame_num_d = i_frame_num;
          tmo_lim_d   = i_timeout;
          frame_cnt_d = '0;
          first_err_d = '0;
          result_d    = RES_PASS;
          err_clr     = 1'b1;
          rst_cnt_d   = '0;
        end
      end
      ST_RESET: begin
        rst_cnt_d = rst_cnt_q + RCW'(1);
        if (i_stop) begin
          state_d  = ST_DONE;
          result_d = RES_ABORT;
        end else if (rst_cnt_q == RST_LAST) begin
          state_d    = ST_LOCK;
          sync_cnt_d = '0;
          gap_cnt_d  = '0;
          tmo_cnt_d  = '0;
        end
      end
      ST_LOCK: begin
        tmo_cnt_d = tmo_cnt_q + TMO_WIDTH'(1);
        gap_cnt_d = (gap_cnt_q == SYNC_GAP_MAX) ? gap_cnt_q : gap_cnt_q + 7'd1;
        if (i_sync_det) begin
          sync_cnt_d = sync_cnt_q + SCW'(1);
          gap_cnt_d  = '0;
          tmo_cnt_d  = '0;
        end else if (gap_cnt_q == SYNC_GAP_MAX) begin
          sync_cnt_d = '0;
        end
        if (i_frame_done) sync_cnt_d = '0;
        if (i_stop) begin
          state_d  = ST_DONE;
          result_d = RES_ABORT;
        end else if (sync_cnt_q == SYNC_LOCK) begin
          state_d    = ST_RUN;
          tmo_cnt_d  = '0;
          err_prev_d = 1'b0;
        end else if (tmo_hit) begin
          state_d  = ST_DONE;
          result_d = RES_TIMEOUT;
        end
      end
      ST_RUN: begin
        tmo_cnt_d  = tmo_cnt_q + TMO_WIDTH'(1);
        err_prev_d = i_check_error;
        if (err_edge && (o_err_cnt == '0)) first_err_d = i_error_status;
        if (i_frame_done) begin
          tmo_cnt_d = '0;
          // Only continuous mode may wrap; a programmed run stops at its target.
          if ((frame_num_q == '0) || (frame_cnt_q != '1)) frame_cnt_d = frame_cnt_q + 16'd1;
        end
        if (i_stop) begin
          state_d  = ST_DONE;
          result_d = RES_ABORT;
        end else if (i_frame_done && (frame_num_q != '0) &&
                     ((frame_cnt_q + 16'd1) == frame_num_q)) begin
          state_d  = ST_DONE;
          // Include an error edge arriving on the final frame's cycle.
          result_d = ((o_err_cnt != '0) || err_edge) ? RES_DATA_ERR : RES_PASS;
        end else if (tmo_hit) begin
          state_d  = ST_DONE;
          result_d = RES_TIMEOUT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      result_q    <= RES_PASS;
      frame_num_q <= '0;
      tmo_lim_q   <= '0;
      tmo_cnt_q   <= '0;
      frame_cnt_q <= '0;
      first_err_q <= '0;
      rst_cnt_q   <= '0;
      sync_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      err_prev_q  <= 1'b0;
      soft_rst_q  <= 1'b0;
      tx_en_q     <= 1'b0;
      rx_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      frame_num_q <= frame_num_d;
      tmo_lim_q   <= tmo_lim_d;
      tmo_cnt_q   <= tmo_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      first_err_q <= first_err_d;
      rst_cnt_q   <= rst_cnt_d;
      sync_cnt_q  <= sync_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      err_prev_q  <= err_prev_d;
      // Control outputs are decoded from the next state so they change on
      // the same edge as the state register.
      soft_rst_q  <= (state_d == ST_RESET);
      tx_en_q     <= (state_d == ST_LOCK) || (state_d == ST_RUN);
      rx_en_q     <= (state_d == ST_RUN);
      busy_q      <= (state_d == ST_RESET) || (state_d == ST_LOCK) || (state_d == ST_RUN);
      done_q      <= (state_d == ST_DONE) && (state_q != ST_DONE);
    end
  end

  tlk2711_sat_cnt #(.WIDTH(16)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (err_clr),
    .en_i  (err_edge),
    .cnt_o (o_err_cnt)
  );

  assign o_soft_rst      = soft_rst_q;
  assign o_tx_test_en    = tx_en_q;
  assign o_rx_start_test = rx_en_q;
  assign o_busy          = busy_q;
  assign o_done          = done_q;
  assign o_result        = result_q;
  assign o_frame_cnt     = frame_cnt_q;
  assign o_first_err     = first_err_q;
  assign o_state         = state_q;

endmodule
